// File: rtl/onehot_step_sequencer.sv
// One-hot step sequencer: walks a single active bit across NUM_STEPS positions
// with per-step dwell, skip mask, four traversal modes, wrap pulse and done flag.
module onehot_step_sequencer #(
    parameter int NUM_STEPS   = 4,
    parameter int DWELL_WIDTH = 4,
    parameter int IDX_WIDTH   = $clog2(NUM_STEPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   restart,
    input  logic [1:0]             mode,
    input  logic [NUM_STEPS-1:0]   skip_mask,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [NUM_STEPS-1:0]   vector,
    output logic [IDX_WIDTH-1:0]   step_idx,
    output logic                   wrap,
    output logic                   done
);

    localparam logic [1:0] MODE_FWD  = 2'b00;
    localparam logic [1:0] MODE_REV  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_SHOT = 2'b11;

    logic [DWELL_WIDTH-1:0] cnt;
    logic                   dir_down;

    logic                 up_found, dn_found, top_found;
    logic [IDX_WIDTH-1:0] up_idx, dn_idx, top_idx;
    logic [IDX_WIDTH-1:0] next_idx;
    logic                 next_dir_down;
    logic                 hold_done;

    // Candidate searches; step 0 is never a skip candidate, it is the fallback.
    always_comb begin
        up_found  = 1'b0;
        up_idx    = '0;
        dn_found  = 1'b0;
        dn_idx    = '0;
        top_found = 1'b0;
        top_idx   = '0;
        for (int i = NUM_STEPS - 1; i >= 0; i--) begin
            if (i != 0 && !skip_mask[i] && i > int'(step_idx)) begin
                up_found = 1'b1;
                up_idx   = IDX_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (i != 0 && !skip_mask[i]) begin
                top_found = 1'b1;
                top_idx   = IDX_WIDTH'(i);
                if (i < int'(step_idx)) begin
                    dn_found = 1'b1;
                    dn_idx   = IDX_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        next_idx      = '0;
        next_dir_down = 1'b0;
        hold_done     = 1'b0;
        case (mode)
            MODE_FWD: next_idx = up_found ? up_idx : '0;
            MODE_REV: begin
                if (step_idx == '0)
                    next_idx = top_found ? top_idx : '0;
                else
                    next_idx = dn_found ? dn_idx : '0;
            end
            MODE_PING: begin
                // Climbing past the top turns around immediately, so endpoints never repeat.
                if (!dir_down && up_found) begin
                    next_idx      = up_idx;
                    next_dir_down = 1'b0;
                end else begin
                    next_idx      = dn_found ? dn_idx : '0;
                    next_dir_down = dn_found;
                end
            end
            default: begin
                if (up_found) begin
                    next_idx = up_idx;
                end else begin
                    next_idx  = step_idx;
                    hold_done = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_idx <= '0;
            vector   <= NUM_STEPS'(1);
            cnt      <= '0;
            dir_down <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else if (restart) begin
            step_idx <= '0;
            vector   <= NUM_STEPS'(1);
            cnt      <= '0;
            dir_down <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else if (!run) begin
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (mode != MODE_PING)
                dir_down <= 1'b0;
            if (mode != MODE_SHOT)
                done <= 1'b0;
            if (done && mode == MODE_SHOT) begin
                cnt <= '0;
            end else if (cnt < dwell) begin
                cnt <= cnt + DWELL_WIDTH'(1);
            end else begin
                cnt <= '0;
                if (hold_done) begin
                    done <= 1'b1;
                end else begin
                    step_idx <= next_idx;
                    vector   <= NUM_STEPS'(1) << next_idx;
                    wrap     <= (next_idx == '0);
                    if (mode == MODE_PING)
                        dir_down <= next_dir_down;
                end
            end
        end
    end

endmodule

// File: tb/tb_onehot_step_sequencer.sv
// Directed self-checking bench for onehot_step_sequencer (NUM_STEPS=4, DWELL_WIDTH=4).
module tb_onehot_step_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic       restart;
    logic [1:0] mode;
    logic [3:0] skip_mask;
    logic [3:0] dwell;
    logic [3:0] vector;
    logic [1:0] step_idx;
    logic       wrap;
    logic       done;

    int checks = 0;
    int errors = 0;

    onehot_step_sequencer #(
        .NUM_STEPS  (4),
        .DWELL_WIDTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .restart  (restart),
        .mode     (mode),
        .skip_mask(skip_mask),
        .dwell    (dwell),
        .vector   (vector),
        .step_idx (step_idx),
        .wrap     (wrap),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
            $error("[TB] %s observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input int exp_idx,
                               input logic exp_wrap, input logic exp_done);
        logic [3:0] exp_vec;
        exp_vec = 4'b0001 << exp_idx;
        check_output({tag, ".vector"}, 32'(vector), 32'(exp_vec));
        check_output({tag, ".idx"}, 32'(step_idx), 32'(exp_idx));
        check_output({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
        check_output({tag, ".done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        int fwd_seq[5]  = '{1, 2, 3, 0, 1};
        int rev_seq[15] = '{0, 0, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 3};
        int png_seq[8]  = '{1, 3, 1, 0, 1, 3, 1, 0};
        int shot_seq[5] = '{1, 2, 3, 3, 3};

        rst = 1'b1; run = 1'b0; restart = 1'b0;
        mode = 2'b00; skip_mask = 4'b0000; dwell = 4'd0;

        // Reset state visible before any clock edge
        #2;
        check_state("reset_async", 0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        check_state("reset_release", 0, 1'b0, 1'b0);

        // Forward, dwell 0
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state($sformatf("fwd_%0d", i), fwd_seq[i], (i == 3), 1'b0);
        end

        // Reverse, dwell 2
        mode = 2'b01; dwell = 4'd2;
        do_restart();
        check_state("rev_restart", 0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check_state($sformatf("rev_%0d", i), rev_seq[i], (i == 11), 1'b0);
        end

        // Ping-pong with step 2 skipped
        mode = 2'b10; skip_mask = 4'b0100; dwell = 4'd0;
        do_restart();
        check_state("png_restart", 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_state($sformatf("png_%0d", i), png_seq[i], (i == 3 || i == 7), 1'b0);
        end

        // Single-shot to done, then restart clears it
        mode = 2'b11; skip_mask = 4'b0000;
        do_restart();
        check_state("shot_restart", 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state($sformatf("shot_%0d", i), shot_seq[i], 1'b0, (i >= 3));
        end
        do_restart();
        check_state("shot_clear", 0, 1'b0, 1'b0);
        tick();
        check_state("shot_again_1", 1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check_state("shot_again_done", 3, 1'b0, 1'b1);
        mode = 2'b00;
        tick();
        check_state("shot_mode_exit", 0, 1'b1, 1'b0);

        // All non-zero steps skipped
        skip_mask = 4'b1110; dwell = 4'd1;
        do_restart();
        check_state("allskip_restart", 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_state($sformatf("allskip_%0d", i), 0, (i == 1 || i == 3), 1'b0);
        end
        mode = 2'b11; dwell = 4'd0;
        do_restart();
        tick();
        check_state("allskip_shot", 0, 1'b0, 1'b1);

        // run low mid-dwell freezes the counter
        mode = 2'b00; skip_mask = 4'b0000; dwell = 4'd3;
        do_restart();
        tick();
        tick();
        check_state("freeze_pre", 0, 1'b0, 1'b0);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state($sformatf("freeze_%0d", i), 0, 1'b0, 1'b0);
        end
        run = 1'b1;
        tick();
        check_state("resume_1", 0, 1'b0, 1'b0);
        tick();
        check_state("resume_2", 1, 1'b0, 1'b0);

        // Lowering dwell mid-step advances on the next edge
        tick();
        check_state("live_dwell_pre", 1, 1'b0, 1'b0);
        dwell = 4'd0;
        tick();
        check_state("live_dwell", 2, 1'b0, 1'b0);

        // Single-shot stalls at step 2 when step 3 is skipped; async reset mid-cycle
        mode = 2'b11; skip_mask = 4'b1000;
        tick();
        check_state("stall_step2", 2, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_state("async_rst_mid", 0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        tick();
        check_state("post_rst", 1, 1'b0, 1'b0);

        // restart beats run=0
        restart = 1'b1; run = 1'b0;
        tick();
        restart = 1'b0;
        check_state("restart_vs_hold", 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_step_sequencer.md
Name: onehot_step_sequencer

Overview:
- Parametrised successor to the team's fixed 4-state one-hot stepping FSM.
- Steps a one-hot output across NUM_STEPS positions.
- Adds programmable dwell per step, a per-step skip mask, four traversal modes (forward, reverse, ping-pong, single-shot), synchronous restart, and wrap/done status.
- Drives step-enable strobes for downstream datapath and test-pattern logic.

Parameters:
NUM_STEPS, 4, number of one-hot steps; legal range 2..32.
DWELL_WIDTH, 4, width of the dwell-length input and internal dwell counter.
IDX_WIDTH, $clog2(NUM_STEPS), width of step_idx output; derived, do not override.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
run  input  1  1 = sequencer advances; 0 = hold all state.
restart  input  1  synchronous return to step 0; priority over run.
mode  input  2  00 forward, 01 reverse, 10 ping-pong, 11 single-shot forward.
skip_mask  input  NUM_STEPS  bit i = 1 skips step i; bit 0 ignored.
dwell  input  DWELL_WIDTH  each step lasts dwell+1 running cycles.
vector  output  NUM_STEPS  one-hot of current step.
step_idx  output  IDX_WIDTH  binary index of current step.
wrap  output  1  one-cycle pulse on entry to step 0 by advance.
done  output  1  single-shot mode has finished.

Behaviour:
- Reset (async, rst=1): step_idx=0, vector=1 (bit 0), dwell counter=0, direction=up, wrap=0, done=0. Outputs are valid immediately; no clock edge is needed.
- vector is always the exact one-hot decode of step_idx. Both are registered state and change on the same edge. Never zero, never multi-hot.
- Priority per edge, highest first: restart, then run=0, then the advance logic.
- restart=1: step_idx=0, counter=0, direction=up, done=0, wrap=0.
- run=0: step_idx, counter, direction and done hold; wrap=0.
- run=1, counter < dwell: counter increments; step unchanged.
- run=1, counter >= dwell (live dwell compare; lowering dwell mid-step advances next edge): counter clears to 0 and step_idx loads the next step.
- Next-step search uses skip_mask sampled that cycle. Step 0 is never skipped.
  - Forward (00): lowest non-skipped index above current; if none, 0.
  - Reverse (01): highest non-skipped index below current, but >0; if none, 0. From step 0, go to highest non-skipped index >0; if none, 0.
  - Ping-pong (10):
    - Direction up: search upward; if none found, flip to down and search downward.
    - Direction down: search downward, reaching 0 if none found.
    - On arriving at step 0, flip to up.
    - Endpoints are never repeated consecutively.
  - Single-shot (11): as forward, but when no non-skipped step lies above current, step holds and done=1. done stays high until restart, rst, or mode leaves 11. Counter holds at 0 while done.
- All steps 1..N-1 skipped: the sequence stays at step 0; wrap pulses once per dwell period. In mode 11, done asserts at the first expiry.
- Mode change takes effect at the next advance. Leaving mode 10 sets direction=up.
- wrap=1 for exactly one cycle, in the cycle after the edge that loaded step 0 via advance. Not asserted for reset or restart.
- No combinational path from inputs to outputs.

Test Plan:
1. N=4, dwell=0, mode=00, mask=0, run=1 after reset -> vector 0001,0010,0100,1000,0001 on consecutive cycles; wrap high with the second 0001.
2. mode=01, dwell=2 -> order 0001,1000,0100,0010,0001; each held 3 cycles; wrap high once per lap.
3. mode=10, mask=0100 -> steps 0,1,3,1,0,1,3; no repeated endpoint; wrap on each return to 0.
4. mode=11, mask=0 -> 0,1,2,3, then holds at 1000 with done=1; restart pulse -> 0001, done=0 next cycle.
5. run toggled low mid-dwell (dwell=3, counter=2) for 5 cycles -> vector and counter frozen; step advances exactly 2 running cycles after run returns high.
6. Async rst asserted mid-step (step 2, non-edge-aligned) -> vector=0001, wrap=0, done=0 immediately. Simultaneous restart and run=0 -> restart wins.
